// File: rtl/mole_scheduler.sv
// Whack-a-mole round controller: spawns LFSR patterns into board_state, times how long
// each stays up, clears the board between rounds and tallies hits and misses.
module mole_scheduler #(
  parameter int          TICK_DIV      = 50000,
  parameter int          ON_TICKS_INIT = 200,
  parameter int          ON_STEP       = 10,
  parameter int          ON_TICKS_MIN  = 40,
  parameter int          GAP_TICKS     = 50,
  parameter int          NUM_ROUNDS    = 20,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] board_state,
  input  logic       score_trigger,
  output logic       load,
  output logic [4:0] loadval,
  output logic       game_active,
  output logic       game_over,
  output logic [7:0] round,
  output logic [7:0] hits,
  output logic [7:0] misses
);

  typedef enum logic [2:0] {IDLE, SPAWN, SHOW, CLEAR, GAP, DONE} state_t;

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]     ON_INIT    = 16'(ON_TICKS_INIT);
  localparam logic [15:0]     ON_DEC     = 16'(ON_STEP);
  localparam logic [15:0]     ON_FLOOR   = 16'(ON_TICKS_MIN);
  localparam logic [15:0]     DEC_THRESH = 16'(ON_TICKS_MIN + ON_STEP);
  localparam logic [15:0]     GAP_LAST   = 16'(GAP_TICKS - 1);
  localparam logic [7:0]      LAST_ROUND = 8'(NUM_ROUNDS);

  state_t          state, state_nx;
  logic [PW-1:0]   presc;
  logic [15:0]     tick_cnt;
  logic [15:0]     on_time;
  logic [15:0]     lfsr;
  logic            tick;
  logic            show_timeout;
  logic            gap_done;
  logic            start_game;
  logic [8:0]      miss_sum;
  logic [4:0]      spawn_pat;

  assign tick         = (presc == PRESC_LAST);
  assign show_timeout = tick && (tick_cnt + 16'd1 == on_time);
  assign gap_done     = tick && (tick_cnt == GAP_LAST);
  assign start_game   = start && ((state == IDLE) || (state == DONE));
  assign miss_sum     = {1'b0, misses} + 9'($countones(board_state));
  // An all-zero LFSR slice would spawn an empty board, so substitute a single mole.
  assign spawn_pat    = (lfsr[4:0] == 5'd0) ? 5'b00100 : lfsr[4:0];

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = SPAWN;
      SPAWN:      state_nx = SHOW;
      SHOW:       if ((board_state == 5'd0) || show_timeout) state_nx = CLEAR;
      CLEAR:      state_nx = GAP;
      GAP:        if (gap_done) state_nx = (round == LAST_ROUND) ? DONE : SPAWN;
      default:    state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= '0;
      tick_cnt    <= '0;
      on_time     <= ON_INIT;
      lfsr        <= LFSR_SEED;
      load        <= 1'b0;
      loadval     <= 5'd0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
      round       <= 8'd0;
      hits        <= 8'd0;
      misses      <= 8'd0;
    end else begin
      state       <= state_nx;
      game_active <= (state_nx == SPAWN) || (state_nx == SHOW) ||
                     (state_nx == CLEAR) || (state_nx == GAP);
      game_over   <= (state_nx == DONE);

      // Outputs are registered from the next state so load lines up with SPAWN/CLEAR.
      load    <= (state_nx == SPAWN) || (state_nx == CLEAR);
      loadval <= (state_nx == SPAWN) ? spawn_pat : 5'd0;

      if (state_nx != state) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (game_active) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) tick_cnt <= tick_cnt + 16'd1;
      end

      if (state == SPAWN)
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (start_game)
        hits <= 8'd0;
      else if (game_active && score_trigger && (hits != 8'hFF))
        hits <= hits + 8'd1;

      if (start_game)
        misses <= 8'd0;
      else if ((state == SHOW) && (board_state != 5'd0) && show_timeout)
        misses <= miss_sum[8] ? 8'hFF : miss_sum[7:0];

      if (start_game) begin
        round   <= 8'd0;
        on_time <= ON_INIT;
      end else if (state == CLEAR) begin
        round   <= round + 8'd1;
        on_time <= (on_time >= DEC_THRESH) ? on_time - ON_DEC : ON_FLOOR;
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: a round-level game model with a simple board
// emulator, random hits and stray start/score pulses, plus a hit-saturation instance.
module tb_mole_scheduler;

  localparam int          TD       = 4;
  localparam int          ON_INIT  = 5;
  localparam int          ON_STEP  = 1;
  localparam int          ON_MIN   = 2;
  localparam int          GAP      = 2;
  localparam int          ROUNDS   = 3;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          TD_SAT   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, score_trigger;
  logic [4:0] board_state;
  logic       load, game_active, game_over;
  logic [4:0] loadval;
  logic [7:0] round, hits, misses;

  logic       start_s, trig_s;
  logic [4:0] board_s;
  logic       load_s, active_s, over_s;
  logic [4:0] loadval_s;
  logic [7:0] round_s, hits_s, misses_s;

  always #5 clk = ~clk;

  mole_scheduler #(
    .TICK_DIV(TD), .ON_TICKS_INIT(ON_INIT), .ON_STEP(ON_STEP), .ON_TICKS_MIN(ON_MIN),
    .GAP_TICKS(GAP), .NUM_ROUNDS(ROUNDS), .LFSR_SEED(SEED)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .board_state(board_state),
    .score_trigger(score_trigger), .load(load), .loadval(loadval),
    .game_active(game_active), .game_over(game_over), .round(round),
    .hits(hits), .misses(misses)
  );

  mole_scheduler #(
    .TICK_DIV(TD_SAT), .ON_TICKS_INIT(ON_INIT), .ON_STEP(ON_STEP), .ON_TICKS_MIN(ON_MIN),
    .GAP_TICKS(GAP), .NUM_ROUNDS(ROUNDS), .LFSR_SEED(SEED)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .board_state(board_s),
    .score_trigger(trig_s), .load(load_s), .loadval(loadval_s),
    .game_active(active_s), .game_over(over_s), .round(round_s),
    .hits(hits_s), .misses(misses_s)
  );

  int          vectors = 0;
  int          errors  = 0;
  int          m_round, m_hits, m_misses, m_on;
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [4:0] pattern(input logic [15:0] s);
    return (s[4:0] == 5'd0) ? 5'b00100 : s[4:0];
  endfunction

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_outputs(input string tag, input logic el, input logic [4:0] ev,
                                input logic ea, input logic eo);
    check({tag, ".load"},    32'(load),        32'(el));
    check({tag, ".loadval"}, 32'(loadval),     32'(ev));
    check({tag, ".active"},  32'(game_active), 32'(ea));
    check({tag, ".over"},    32'(game_over),   32'(eo));
    check({tag, ".round"},   32'(round),       32'(m_round));
    check({tag, ".hits"},    32'(hits),        32'(m_hits));
    check({tag, ".misses"},  32'(misses),      32'(m_misses));
  endtask

  // Plays one full game from IDLE/DONE; hit_pct is the per-cycle chance of knocking a mole down.
  task automatic play_game(input int hit_pct);
    logic [4:0] pat;
    logic [4:0] hit_mask;
    bit         ended;
    int         k, idx;
    start = 1'b1;
    step();
    start = 1'b0;
    m_round = 0; m_hits = 0; m_misses = 0; m_on = ON_INIT;
    for (int r = 0; r < ROUNDS; r++) begin
      pat = pattern(m_lfsr);
      expect_outputs("spawn", 1'b1, pat, 1'b1, 1'b0);
      m_lfsr = lfsr_next(m_lfsr);
      step();
      board_state = pat;
      k = 0;
      do begin
        expect_outputs("show", 1'b0, 5'd0, 1'b1, 1'b0);
        ended = (board_state == 5'd0) || (k == m_on * TD - 1);
        if ((board_state != 5'd0) && (k == m_on * TD - 1))
          m_misses = sat8(m_misses + $countones(board_state));
        hit_mask = 5'd0;
        if ((board_state != 5'd0) && ($urandom_range(99) < hit_pct)) begin
          do idx = $urandom_range(4); while (!board_state[idx]);
          hit_mask[idx] = 1'b1;
          score_trigger = 1'b1;
          m_hits = sat8(m_hits + 1);
        end
        if ($urandom_range(15) == 0) start = 1'b1;
        step();
        board_state   = board_state & ~hit_mask;
        score_trigger = 1'b0;
        start         = 1'b0;
        k++;
      end while (!ended);
      expect_outputs("clear", 1'b1, 5'd0, 1'b1, 1'b0);
      m_round++;
      m_on = (m_on - ON_STEP < ON_MIN) ? ON_MIN : m_on - ON_STEP;
      step();
      board_state = 5'd0;
      for (int g = 0; g < GAP * TD; g++) begin
        expect_outputs("gap", 1'b0, 5'd0, 1'b1, 1'b0);
        if ($urandom_range(3) == 0) begin
          score_trigger = 1'b1;
          m_hits = sat8(m_hits + 1);
        end
        step();
        score_trigger = 1'b0;
      end
    end
    expect_outputs("done", 1'b0, 5'd0, 1'b0, 1'b1);
    score_trigger = 1'b1;
    step();
    score_trigger = 1'b0;
    expect_outputs("done_hold", 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; score_trigger = 1'b0; board_state = 5'd0;
    start_s = 1'b0; trig_s = 1'b0; board_s = 5'd0;
    m_round = 0; m_hits = 0; m_misses = 0; m_on = ON_INIT; m_lfsr = SEED;
    @(negedge clk);
    @(negedge clk);
    expect_outputs("reset", 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    score_trigger = 1'b1;
    step();
    score_trigger = 1'b0;
    expect_outputs("idle_trig", 1'b0, 5'd0, 1'b0, 1'b0);

    play_game(0);
    play_game(30);
    play_game(80);

    // Abort a game mid-SHOW with an asynchronous reset between clock edges.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    board_state = 5'b10101;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    m_round = 0; m_hits = 0; m_misses = 0; m_on = ON_INIT; m_lfsr = SEED;
    expect_outputs("async_rst", 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    expect_outputs("post_rst", 1'b0, 5'd0, 1'b0, 1'b0);
    play_game(50);

    // Saturation: score every cycle of a long SHOW while the board never empties.
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    check("sat.spawn_load", 32'(load_s), 32'd1);
    step();
    board_s = 5'b11111;
    for (int i = 0; i < 300; i++) begin
      trig_s = 1'b1;
      step();
      if (i == 99) check("sat.hits_100", 32'(hits_s), 32'd100);
    end
    trig_s = 1'b0;
    check("sat.hits_255", 32'(hits_s), 32'd255);
    check("sat.active", 32'(active_s), 32'd1);
    check("sat.misses_mid", 32'(misses_s), 32'd0);
    for (int i = 0; i < 20; i++) step();
    check("sat.clear_load", 32'(load_s), 32'd1);
    check("sat.clear_loadval", 32'(loadval_s), 32'd0);
    check("sat.misses", 32'(misses_s), 32'd5);
    check("sat.hits_hold", 32'(hits_s), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
